spi_cmd_receiver: RTL and testbench

- Receives CPU command frames over a mode-0 SPI link (spi_clk / spi_cs_n / spi_mosi), sampled in the system clk domain.
- Decodes each frame into one of two request types:
  - a 64-bit word write toward mem_controller;
  - a stream of byte writes into the char_display character buffer.
- Sits directly upstream of mem_controller and char_display and replaces the built-in memory-test sequencer as their request source.

---
 rtl/spi_cmd_receiver_pkg.sv | 29 ++
 rtl/spi_byte_rx.sv | 93 +++++++++
 rtl/spi_cmd_receiver.sv | 181 ++++++++++++++++++
 tb/tb_spi_cmd_receiver.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_receiver_pkg
// Brief    : Shared opcodes, field sizes and frame-state encoding for the
//            SPI command receiver.
// Revision : 1.0 - initial release
// ============================================================================
package spi_cmd_receiver_pkg;

    // Frame opcodes (first byte of every frame)
    localparam logic [7:0] OPC_MEM_WRITE  = 8'h01;
    localparam logic [7:0] OPC_CHAR_WRITE = 8'h02;

    // Field lengths in bytes for a memory write frame
    localparam int MEM_ADDR_BYTES = 3;
    localparam int MEM_DATA_BYTES = 8;

    // Frame-state encoding
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_OPCODE = 3'd1;
    localparam logic [STATE_W-1:0] ST_MADDR  = 3'd2;
    localparam logic [STATE_W-1:0] ST_MDATA  = 3'd3;
    localparam logic [STATE_W-1:0] ST_CADDR  = 3'd4;
    localparam logic [STATE_W-1:0] ST_CDATA  = 3'd5;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd6;

endpackage
`default_nettype wire

// File: rtl/spi_byte_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_rx
// Brief    : Synchronises the mode-0 SPI lines into clk, detects spi_clk
//            rising edges and chip-select edges, and assembles MSB-first
//            bytes.
// Revision : 1.0 - initial release
// ============================================================================
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_start,
    output logic       frame_end
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;
    logic [2:0]             r_bitcnt;
    logic [6:0]             r_shift;
    logic [7:0]             r_byte;
    logic                   r_byte_valid;
    logic                   r_frame_start;
    logic                   r_frame_end;

    logic w_sclk_s;
    logic w_cs_s;
    logic w_mosi_s;
    logic w_sclk_rise;
    logic w_cs_fall;
    logic w_cs_rise;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
    assign w_cs_fall   = ~w_cs_s & r_cs_prev;
    assign w_cs_rise   = w_cs_s & ~r_cs_prev;

    // Synchroniser, edge detection and MSB-first byte shifter.
    // Chip select resets to "low" so that leaving reset in the middle of a
    // frame never looks like a fresh frame start; only a real cs fall does.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk_sync   <= '0;
            r_cs_sync     <= '0;
            r_mosi_sync   <= '0;
            r_sclk_prev   <= 1'b0;
            r_cs_prev     <= 1'b0;
            r_bitcnt      <= 3'd0;
            r_shift       <= 7'd0;
            r_byte        <= 8'd0;
            r_byte_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
        end else begin
            r_sclk_sync   <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
            r_cs_sync     <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync   <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sclk_prev   <= w_sclk_s;
            r_cs_prev     <= w_cs_s;
            r_byte_valid  <= 1'b0;
            r_frame_start <= w_cs_fall;
            r_frame_end   <= w_cs_rise;
            if (w_cs_fall || w_cs_rise) begin
                r_bitcnt <= 3'd0;
            end else if (w_sclk_rise && !w_cs_s) begin
                r_shift  <= {r_shift[5:0], w_mosi_s};
                r_bitcnt <= r_bitcnt + 3'd1;
                if (r_bitcnt == 3'd7) begin
                    r_byte       <= {r_shift, w_mosi_s};
                    r_byte_valid <= 1'b1;
                end
            end
        end
    end

    assign rx_byte     = r_byte;
    assign byte_valid  = r_byte_valid;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;

endmodule
`default_nettype wire

// File: rtl/spi_cmd_receiver.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_receiver
// Brief    : Decodes SPI command frames into 64-bit memory write requests and
//            character-buffer byte writes; tracks the in-flight memory write.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int MEM_ADDR_W  = 20,
    parameter int CHAR_ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   spi_clk,
    input  logic                   spi_cs_n,
    input  logic                   spi_mosi,
    output logic [MEM_ADDR_W-1:0]  mem_addr,
    output logic [63:0]            mem_wrdata,
    output logic                   mem_write,
    input  logic                   mem_ready,
    output logic [CHAR_ADDR_W-1:0] char_wraddr,
    output logic [7:0]             char_wrdata,
    output logic                   char_we,
    output logic                   err_overflow,
    output logic                   err_opcode
);

    import spi_cmd_receiver_pkg::*;

    localparam logic [3:0] c_maddr_last = 4'(MEM_ADDR_BYTES - 1);
    localparam logic [3:0] c_mdata_last = 4'(MEM_DATA_BYTES - 1);
    localparam int         c_mdata_acc_w = 8 * (MEM_DATA_BYTES - 1);

    logic [7:0] w_rx_byte;
    logic       w_byte_valid;
    logic       w_frame_start;
    logic       w_frame_end;

    logic [STATE_W-1:0]     r_state;
    logic [3:0]             r_cnt;
    logic [MEM_ADDR_W-1:0]  r_maddr_acc;
    logic [c_mdata_acc_w-1:0] r_mdata_acc;
    logic [CHAR_ADDR_W-1:0] r_caddr_acc;
    logic [1:0]             r_inflight;
    logic [MEM_ADDR_W-1:0]  r_mem_addr;
    logic [63:0]            r_mem_wrdata;
    logic                   r_mem_write;
    logic [CHAR_ADDR_W-1:0] r_char_wraddr;
    logic [7:0]             r_char_wrdata;
    logic                   r_char_we;
    logic                   r_err_overflow;
    logic                   r_err_opcode;

    spi_byte_rx #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_byte_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_clk     (spi_clk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .rx_byte     (w_rx_byte),
        .byte_valid  (w_byte_valid),
        .frame_start (w_frame_start),
        .frame_end   (w_frame_end)
    );

    // Frame FSM, field assembly, request strobes and in-flight tracking.
    // Address accumulators keep only the low bits, which is exactly the
    // truncation the wider big-endian wire fields call for.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 4'd0;
            r_maddr_acc    <= '0;
            r_mdata_acc    <= '0;
            r_caddr_acc    <= '0;
            r_inflight     <= 2'd0;
            r_mem_addr     <= '0;
            r_mem_wrdata   <= 64'd0;
            r_mem_write    <= 1'b0;
            r_char_wraddr  <= '0;
            r_char_wrdata  <= 8'd0;
            r_char_we      <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_opcode   <= 1'b0;
        end else begin
            r_mem_write    <= 1'b0;
            r_char_we      <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_opcode   <= 1'b0;

            if (mem_ready && (r_inflight != 2'd0)) begin
                r_inflight <= r_inflight - 2'd1;
            end

            if (r_char_we) begin
                r_char_wraddr <= r_char_wraddr + 1'b1;
            end

            if (w_frame_end) begin
                r_state <= ST_IDLE;
                r_cnt   <= 4'd0;
            end else if (w_frame_start) begin
                r_state <= ST_OPCODE;
                r_cnt   <= 4'd0;
            end else if (w_byte_valid) begin
                case (r_state)
                    ST_OPCODE: begin
                        r_cnt <= 4'd0;
                        if (w_rx_byte == OPC_MEM_WRITE) begin
                            r_state <= ST_MADDR;
                        end else if (w_rx_byte == OPC_CHAR_WRITE) begin
                            r_state <= ST_CADDR;
                        end else begin
                            r_err_opcode <= 1'b1;
                            r_state      <= ST_DONE;
                        end
                    end
                    ST_MADDR: begin
                        r_maddr_acc <= {r_maddr_acc[MEM_ADDR_W-9:0], w_rx_byte};
                        if (r_cnt == c_maddr_last) begin
                            r_cnt   <= 4'd0;
                            r_state <= ST_MDATA;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    ST_MDATA: begin
                        if (r_cnt == c_mdata_last) begin
                            // Only one write may be outstanding toward the
                            // memory controller; later ones are dropped.
                            if (r_inflight == 2'd0) begin
                                r_mem_write  <= 1'b1;
                                r_mem_addr   <= r_maddr_acc;
                                r_mem_wrdata <= {r_mdata_acc, w_rx_byte};
                                r_inflight   <= 2'd2;
                            end else begin
                                r_err_overflow <= 1'b1;
                            end
                            r_cnt   <= 4'd0;
                            r_state <= ST_DONE;
                        end else begin
                            r_mdata_acc <= {r_mdata_acc[c_mdata_acc_w-9:0], w_rx_byte};
                            r_cnt       <= r_cnt + 4'd1;
                        end
                    end
                    ST_CADDR: begin
                        if (r_cnt == 4'd0) begin
                            r_caddr_acc <= {r_caddr_acc[CHAR_ADDR_W-9:0], w_rx_byte};
                            r_cnt       <= 4'd1;
                        end else begin
                            r_char_wraddr <= {r_caddr_acc[CHAR_ADDR_W-9:0], w_rx_byte};
                            r_cnt         <= 4'd0;
                            r_state       <= ST_CDATA;
                        end
                    end
                    ST_CDATA: begin
                        r_char_wrdata <= w_rx_byte;
                        r_char_we     <= 1'b1;
                    end
                    default: begin
                        // IDLE and DONE ignore incoming bytes
                    end
                endcase
            end
        end
    end

    assign mem_addr     = r_mem_addr;
    assign mem_wrdata   = r_mem_wrdata;
    assign mem_write    = r_mem_write;
    assign char_wraddr  = r_char_wraddr;
    assign char_wrdata  = r_char_wrdata;
    assign char_we      = r_char_we;
    assign err_overflow = r_err_overflow;
    assign err_opcode   = r_err_opcode;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cmd_receiver
// Brief    : Self-checking bench for spi_cmd_receiver: drives SPI frames and
//            compares observed requests with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_receiver;

    localparam int SYNC_STAGES = 2;
    localparam int MEM_ADDR_W  = 20;
    localparam int CHAR_ADDR_W = 10;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   spi_clk = 1'b0;
    logic                   spi_cs_n = 1'b1;
    logic                   spi_mosi = 1'b0;
    logic                   mem_ready = 1'b0;
    logic [MEM_ADDR_W-1:0]  mem_addr;
    logic [63:0]            mem_wrdata;
    logic                   mem_write;
    logic [CHAR_ADDR_W-1:0] char_wraddr;
    logic [7:0]             char_wrdata;
    logic                   char_we;
    logic                   err_overflow;
    logic                   err_opcode;

    always #5 clk = ~clk;

    spi_cmd_receiver #(
        .SYNC_STAGES (SYNC_STAGES),
        .MEM_ADDR_W  (MEM_ADDR_W),
        .CHAR_ADDR_W (CHAR_ADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_clk      (spi_clk),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .mem_addr     (mem_addr),
        .mem_wrdata   (mem_wrdata),
        .mem_write    (mem_write),
        .mem_ready    (mem_ready),
        .char_wraddr  (char_wraddr),
        .char_wrdata  (char_wrdata),
        .char_we      (char_we),
        .err_overflow (err_overflow),
        .err_opcode   (err_opcode)
    );

    int total = 0;
    int bad   = 0;
    int half  = 25;

    logic [7:0]  tx_q[$];
    logic [83:0] exp_mem[$];
    logic [83:0] got_mem[$];
    logic [17:0] exp_chr[$];
    logic [17:0] got_chr[$];
    int exp_ovf = 0, got_ovf = 0, exp_opc = 0, got_opc = 0;
    int m_inflight = 0;

    // Monitor: every strobe cycle is logged, so a stretched pulse shows up
    // as extra entries.
    always @(negedge clk) begin
        if (mem_write)    got_mem.push_back({mem_addr, mem_wrdata});
        if (char_we)      got_chr.push_back({char_wraddr, char_wrdata});
        if (err_overflow) got_ovf++;
        if (err_opcode)   got_opc++;
    end

    // Frame-level reference: what one complete frame in tx_q must produce.
    task automatic model_frame();
        int n;
        n = tx_q.size();
        if (n == 0) return;
        if (tx_q[0] == 8'h01) begin
            if (n >= 12) begin
                logic [23:0] a;
                logic [63:0] d;
                a = {tx_q[1], tx_q[2], tx_q[3]};
                d = 64'd0;
                for (int i = 4; i < 12; i++) d = (d << 8) | 64'(tx_q[i]);
                if (m_inflight == 0) begin
                    exp_mem.push_back({a[MEM_ADDR_W-1:0], d});
                    m_inflight = 2;
                end else begin
                    exp_ovf++;
                end
            end
        end else if (tx_q[0] == 8'h02) begin
            if (n >= 3) begin
                int ad;
                ad = (int'(tx_q[1]) * 256 + int'(tx_q[2])) % (1 << CHAR_ADDR_W);
                for (int i = 3; i < n; i++) begin
                    exp_chr.push_back({10'(ad), tx_q[i]});
                    ad = (ad + 1) % (1 << CHAR_ADDR_W);
                end
            end
        end else begin
            exp_opc++;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = b[i];
            #(half);
            spi_clk = 1'b1;
            #(half);
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_frame();
        half = $urandom_range(20, 40);
        spi_cs_n = 1'b0;
        #(half);
        foreach (tx_q[i]) spi_byte(tx_q[i]);
        #(half);
        spi_cs_n = 1'b1;
        repeat (12) @(posedge clk);
        model_frame();
    endtask

    task automatic pulse_ready();
        @(posedge clk); #1 mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        if (m_inflight > 0) m_inflight--;
    endtask

    task automatic make_mem(input logic [23:0] a);
        tx_q.delete();
        tx_q.push_back(8'h01);
        tx_q.push_back(a[23:16]);
        tx_q.push_back(a[15:8]);
        tx_q.push_back(a[7:0]);
        repeat (8) tx_q.push_back(8'($urandom));
    endtask

    task automatic make_chr(input logic [15:0] a, input int len);
        tx_q.delete();
        tx_q.push_back(8'h02);
        tx_q.push_back(a[15:8]);
        tx_q.push_back(a[7:0]);
        repeat (len) tx_q.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        spi_cs_n = 1'b0;
        spi_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write got=%b want=0", mem_write); end
        total++; if (char_we !== 1'b0) begin bad++; $display("FAIL reset_char_we got=%b want=0", char_we); end
        total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL reset_err_overflow got=%b want=0", err_overflow); end
        total++; if (err_opcode !== 1'b0) begin bad++; $display("FAIL reset_err_opcode got=%b want=0", err_opcode); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
        total++; if (mem_wrdata !== 64'd0) begin bad++; $display("FAIL reset_mem_wrdata got=%h want=0", mem_wrdata); end
        total++; if (char_wraddr !== '0) begin bad++; $display("FAIL reset_char_wraddr got=%h want=0", char_wraddr); end
        total++; if (char_wrdata !== 8'd0) begin bad++; $display("FAIL reset_char_wrdata got=%h want=0", char_wrdata); end
        spi_clk = 1'b0;
        spi_cs_n = 1'b1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_mem_write();
        tx_q = '{8'h01, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h07, 8'h0A, 8'h57,
                 8'hED, 8'hC0, 8'hFF, 8'hEE};
        send_frame();
        pulse_ready(); pulse_ready();
        total++;
        if (got_mem.size() < 1 || got_mem[0] !== {20'h0001F, 64'h00070A57EDC0FFEE}) begin
            bad++; $display("FAIL mem_directed got=%h want=%h", (got_mem.size() > 0) ? got_mem[0] : 84'd0,
                            {20'h0001F, 64'h00070A57EDC0FFEE});
        end
        // A second write is only accepted if the in-flight count returned to 0
        make_mem(24'($urandom));
        send_frame();
        pulse_ready(); pulse_ready();
        total++; if (got_mem.size() != exp_mem.size()) begin bad++; $display("FAIL mem_count got=%0d want=%0d", got_mem.size(), exp_mem.size()); end
        foreach (exp_mem[i]) if (i < got_mem.size()) begin
            total++; if (got_mem[i] !== exp_mem[i]) begin bad++; $display("FAIL mem_req[%0d] got=%h want=%h", i, got_mem[i], exp_mem[i]); end
        end
        total++; if (got_ovf != exp_ovf) begin bad++; $display("FAIL mem_overflow_count got=%0d want=%0d", got_ovf, exp_ovf); end
        total++; if (got_chr.size() != 0) begin bad++; $display("FAIL mem_stray_char got=%0d want=0", got_chr.size()); end
        got_mem.delete(); exp_mem.delete(); got_chr.delete(); exp_chr.delete();
    endtask

    task automatic test_char_write();
        tx_q = '{8'h02, 8'h03, 8'hFE, 8'h41, 8'h42, 8'h43};
        send_frame();
        total++;
        if (got_chr.size() < 3 || got_chr[2] !== {10'h000, 8'h43}) begin
            bad++; $display("FAIL char_wrap got=%h want=%h", (got_chr.size() > 2) ? got_chr[2] : 18'd0, {10'h000, 8'h43});
        end
        make_chr(16'($urandom_range(1016, 1023)) | 16'($urandom) & 16'hFC00, $urandom_range(1, 6));
        send_frame();
        total++; if (got_chr.size() != exp_chr.size()) begin bad++; $display("FAIL char_count got=%0d want=%0d", got_chr.size(), exp_chr.size()); end
        foreach (exp_chr[i]) if (i < got_chr.size()) begin
            total++; if (got_chr[i] !== exp_chr[i]) begin bad++; $display("FAIL char_wr[%0d] got=%h want=%h", i, got_chr[i], exp_chr[i]); end
        end
        total++; if (got_mem.size() != 0) begin bad++; $display("FAIL char_stray_mem got=%0d want=0", got_mem.size()); end
        got_mem.delete(); exp_mem.delete(); got_chr.delete(); exp_chr.delete();
    endtask

    task automatic test_back_to_back();
        make_mem(24'($urandom));
        send_frame();
        make_mem(24'($urandom));
        send_frame();
        total++; if (got_ovf != exp_ovf) begin bad++; $display("FAIL b2b_overflow got=%0d want=%0d", got_ovf, exp_ovf); end
        total++; if (got_mem.size() != exp_mem.size()) begin bad++; $display("FAIL b2b_mem_count got=%0d want=%0d", got_mem.size(), exp_mem.size()); end
        if (exp_mem.size() > 0) begin
            total++;
            if ({mem_addr, mem_wrdata} !== exp_mem[0]) begin
                bad++; $display("FAIL b2b_hold got=%h want=%h", {mem_addr, mem_wrdata}, exp_mem[0]);
            end
        end
        pulse_ready(); pulse_ready();
        got_mem.delete(); exp_mem.delete();
    endtask

    task automatic test_bad_opcode();
        tx_q = '{8'h55, 8'hA3};
        send_frame();
        tx_q.delete();
        tx_q.push_back(8'($urandom_range(3, 255)));
        repeat ($urandom_range(0, 4)) tx_q.push_back(8'($urandom));
        send_frame();
        total++; if (got_opc != exp_opc) begin bad++; $display("FAIL opcode_err_count got=%0d want=%0d", got_opc, exp_opc); end
        total++; if (got_mem.size() + got_chr.size() != 0) begin bad++; $display("FAIL opcode_stray got=%0d want=0", got_mem.size() + got_chr.size()); end
        got_mem.delete(); got_chr.delete();
    endtask

    task automatic test_partial();
        make_mem(24'($urandom));
        repeat (3) void'(tx_q.pop_back());
        send_frame();
        make_mem(24'h000002);
        send_frame();
        pulse_ready(); pulse_ready();
        total++; if (got_mem.size() != exp_mem.size()) begin bad++; $display("FAIL partial_count got=%0d want=%0d", got_mem.size(), exp_mem.size()); end
        foreach (exp_mem[i]) if (i < got_mem.size()) begin
            total++; if (got_mem[i] !== exp_mem[i]) begin bad++; $display("FAIL partial_req[%0d] got=%h want=%h", i, got_mem[i], exp_mem[i]); end
        end
        got_mem.delete(); exp_mem.delete();
    endtask

    task automatic test_reset_mid();
        logic [7:0] c1;
        // Leave a write in flight; reset must clear it
        make_mem(24'($urandom) | 24'h000100);
        send_frame();
        c1 = 8'($urandom);
        half = 25;
        spi_cs_n = 1'b0;
        #(half);
        spi_byte(8'h02); spi_byte(8'h03); spi_byte(8'h10); spi_byte(c1);
        repeat (8) @(posedge clk);
        exp_chr.push_back({10'h310, c1});
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({mem_write, char_we, err_overflow, err_opcode, mem_addr, mem_wrdata, char_wraddr, char_wrdata} !== '0) begin
            bad++; $display("FAIL midreset_outputs got=%h/%h/%h/%h want=0", mem_addr, mem_wrdata, char_wraddr, char_wrdata);
        end
        rst_n = 1'b1;
        m_inflight = 0;
        spi_byte(8'($urandom)); spi_byte(8'($urandom));
        #(half);
        spi_cs_n = 1'b1;
        repeat (12) @(posedge clk);
        make_mem(24'($urandom));
        send_frame();
        pulse_ready(); pulse_ready();
        total++; if (got_chr.size() != exp_chr.size()) begin bad++; $display("FAIL midreset_char_count got=%0d want=%0d", got_chr.size(), exp_chr.size()); end
        foreach (exp_chr[i]) if (i < got_chr.size()) begin
            total++; if (got_chr[i] !== exp_chr[i]) begin bad++; $display("FAIL midreset_char[%0d] got=%h want=%h", i, got_chr[i], exp_chr[i]); end
        end
        total++; if (got_mem.size() != exp_mem.size()) begin bad++; $display("FAIL midreset_mem_count got=%0d want=%0d", got_mem.size(), exp_mem.size()); end
        foreach (exp_mem[i]) if (i < got_mem.size()) begin
            total++; if (got_mem[i] !== exp_mem[i]) begin bad++; $display("FAIL midreset_mem[%0d] got=%h want=%h", i, got_mem[i], exp_mem[i]); end
        end
        total++; if (got_ovf != exp_ovf) begin bad++; $display("FAIL midreset_overflow got=%0d want=%0d", got_ovf, exp_ovf); end
        got_mem.delete(); exp_mem.delete(); got_chr.delete(); exp_chr.delete();
    endtask

    task automatic test_random();
        for (int k = 0; k < 10; k++) begin
            int kind;
            kind = $urandom_range(0, 3);
            case (kind)
                0: make_mem(24'($urandom));
                1: make_chr(16'($urandom), $urandom_range(0, 5));
                2: begin
                    tx_q.delete();
                    tx_q.push_back(8'($urandom_range(3, 255)));
                    tx_q.push_back(8'($urandom));
                end
                default: begin
                    make_mem(24'($urandom));
                    repeat ($urandom_range(1, 10)) void'(tx_q.pop_back());
                end
            endcase
            send_frame();
            repeat ($urandom_range(0, 3)) pulse_ready();
        end
        total++; if (got_mem.size() != exp_mem.size()) begin bad++; $display("FAIL rand_mem_count got=%0d want=%0d", got_mem.size(), exp_mem.size()); end
        foreach (exp_mem[i]) if (i < got_mem.size()) begin
            total++; if (got_mem[i] !== exp_mem[i]) begin bad++; $display("FAIL rand_mem[%0d] got=%h want=%h", i, got_mem[i], exp_mem[i]); end
        end
        total++; if (got_chr.size() != exp_chr.size()) begin bad++; $display("FAIL rand_char_count got=%0d want=%0d", got_chr.size(), exp_chr.size()); end
        foreach (exp_chr[i]) if (i < got_chr.size()) begin
            total++; if (got_chr[i] !== exp_chr[i]) begin bad++; $display("FAIL rand_char[%0d] got=%h want=%h", i, got_chr[i], exp_chr[i]); end
        end
        total++; if (got_ovf != exp_ovf) begin bad++; $display("FAIL rand_overflow got=%0d want=%0d", got_ovf, exp_ovf); end
        total++; if (got_opc != exp_opc) begin bad++; $display("FAIL rand_opcode got=%0d want=%0d", got_opc, exp_opc); end
    endtask

    initial begin
        test_reset();
        test_mem_write();
        test_char_write();
        test_back_to_back();
        test_bad_opcode();
        test_partial();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
